// File: rtl/pwm_cfg_ctrl_if.sv
// Configuration bus for pwm_cfg_ctrl: two request channels (A and B)
// plus the PWM write port and the live counter fed back from the PWM.
interface pwm_cfg_ctrl_if #(
   parameter int W = 16
);
   logic         a_valid;
   logic [W-1:0] a_top;
   logic [W-1:0] a_cmp;
   logic         a_restart;
   logic         a_ready;

   logic         b_valid;
   logic [W-1:0] b_top;
   logic [W-1:0] b_cmp;
   logic         b_restart;
   logic         b_ready;

   logic [W-1:0] cnt;
   logic [1:0]   sel;
   logic [W-1:0] d;

   // Requesters and PWM datapath side
   modport master (
      output a_valid, a_top, a_cmp, a_restart,
      input  a_ready,
      output b_valid, b_top, b_cmp, b_restart,
      input  b_ready,
      output cnt,
      input  sel, d
   );

   // Configuration controller side
   modport slave (
      input  a_valid, a_top, a_cmp, a_restart,
      output a_ready,
      input  b_valid, b_top, b_cmp, b_restart,
      output b_ready,
      input  cnt,
      output sel, d
   );
endinterface

// File: rtl/pwm_cfg_ctrl.sv
// PWM configuration controller: arbitrates two requesters round-robin,
// then writes top, cmp and (optionally) a counter clear into the PWM,
// deferring the top write to a counter wrap once the PWM is initialised.
module pwm_cfg_ctrl #(
   parameter int W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pwm_cfg_ctrl_if.slave        cfg_bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [W-1:0]         cur_top_o,
   output logic [W-1:0]         cur_cmp_o
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_WRAP,
      LD_TOP,
      LD_CMP,
      LD_CNT,
      FIN
   } state_t;

   state_t       state_q, state_d;
   logic         init_q, init_d;
   logic         last_b_q, last_b_d;
   logic [W-1:0] sh_top_q, sh_top_d;
   logic [W-1:0] sh_cmp_q, sh_cmp_d;
   logic         sh_restart_q, sh_restart_d;
   logic [W-1:0] cur_top_q, cur_top_d;
   logic [W-1:0] cur_cmp_q, cur_cmp_d;

   logic         grant_a;
   logic         grant_b;
   logic [1:0]   wr_sel;
   logic [W-1:0] wr_data;

   // Round-robin grant, only offered while idle and out of reset
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst && state_q == IDLE) begin
         if (cfg_bus.a_valid && cfg_bus.b_valid) begin
            grant_a = last_b_q;
            grant_b = !last_b_q;
         end else begin
            grant_a = cfg_bus.a_valid;
            grant_b = cfg_bus.b_valid;
         end
      end
   end

   // Next-state logic and PWM write-bus decode
   always_comb begin
      state_d      = state_q;
      init_d       = init_q;
      last_b_d     = last_b_q;
      sh_top_d     = sh_top_q;
      sh_cmp_d     = sh_cmp_q;
      sh_restart_d = sh_restart_q;
      cur_top_d    = cur_top_q;
      cur_cmp_d    = cur_cmp_q;
      wr_sel       = 2'b00;
      wr_data      = '0;

      case (state_q)
         IDLE: begin
            if (grant_a) begin
               sh_top_d     = cfg_bus.a_top;
               sh_cmp_d     = cfg_bus.a_cmp;
               sh_restart_d = cfg_bus.a_restart;
               last_b_d     = 1'b0;
               state_d      = init_q ? WAIT_WRAP : LD_TOP;
            end else if (grant_b) begin
               sh_top_d     = cfg_bus.b_top;
               sh_cmp_d     = cfg_bus.b_cmp;
               sh_restart_d = cfg_bus.b_restart;
               last_b_d     = 1'b1;
               state_d      = init_q ? WAIT_WRAP : LD_TOP;
            end
         end
         WAIT_WRAP: begin
            if (cfg_bus.cnt >= cur_top_q) begin
               wr_sel    = 2'b10;
               wr_data   = sh_top_q;
               cur_top_d = sh_top_q;
               state_d   = LD_CMP;
            end
         end
         LD_TOP: begin
            wr_sel    = 2'b10;
            wr_data   = sh_top_q;
            cur_top_d = sh_top_q;
            state_d   = LD_CMP;
         end
         LD_CMP: begin
            wr_sel    = 2'b01;
            wr_data   = sh_cmp_q;
            cur_cmp_d = sh_cmp_q;
            state_d   = (sh_restart_q || !init_q) ? LD_CNT : FIN;
         end
         LD_CNT: begin
            wr_sel  = 2'b11;
            wr_data = '0;
            state_d = FIN;
         end
         FIN: begin
            init_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and shadow registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         init_q       <= 1'b0;
         last_b_q     <= 1'b1;
         sh_top_q     <= '0;
         sh_cmp_q     <= '0;
         sh_restart_q <= 1'b0;
         cur_top_q    <= '0;
         cur_cmp_q    <= '0;
      end else begin
         state_q      <= state_d;
         init_q       <= init_d;
         last_b_q     <= last_b_d;
         sh_top_q     <= sh_top_d;
         sh_cmp_q     <= sh_cmp_d;
         sh_restart_q <= sh_restart_d;
         cur_top_q    <= cur_top_d;
         cur_cmp_q    <= cur_cmp_d;
      end
   end

   assign cfg_bus.a_ready = grant_a;
   assign cfg_bus.b_ready = grant_b;
   assign cfg_bus.sel     = wr_sel;
   assign cfg_bus.d       = wr_data;
   assign busy_o          = (state_q != IDLE);
   assign done_o          = (state_q == FIN);
   assign cur_top_o       = cur_top_q;
   assign cur_cmp_o       = cur_cmp_q;

endmodule
